// File: rtl/sram_responder_pkg.sv
// Shared types for the SRAM bus responder: bus widths, responder states and
// the decoded per-cycle request.
package sram_pkg;

    localparam int SRAM_DATA_W = 16;
    localparam int SRAM_ADDR_W = 18;

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        READ_WAIT,
        READ_DRIVE
    } sram_rsp_state_t;

    typedef enum logic [1:0] {
        NONE,
        RD,
        WR
    } sram_req_t;

    // Write wins over output enable; a deselected chip is always NONE.
    function automatic sram_req_t decode_req(input logic ce_n,
                                             input logic we_n,
                                             input logic oe_n);
        if (ce_n) return NONE;
        if (!we_n) return WR;
        if (!oe_n) return RD;
        return NONE;
    endfunction

endpackage

// File: rtl/sram_responder_if.sv
// Unidirectional SRAM strobes and address driven by the memory controller.
// The bidirectional data bus stays a plain inout pin on the responder.
interface sram_responder_if;
    import sram_pkg::*;

    logic [SRAM_ADDR_W-1:0] SRAM_ADDR;
    logic                   SRAM_UB_N;
    logic                   SRAM_LB_N;
    logic                   SRAM_WE_N;
    logic                   SRAM_CE_N;
    logic                   SRAM_OE_N;

    modport master (
        output SRAM_ADDR, SRAM_UB_N, SRAM_LB_N, SRAM_WE_N, SRAM_CE_N, SRAM_OE_N
    );

    modport slave (
        input  SRAM_ADDR, SRAM_UB_N, SRAM_LB_N, SRAM_WE_N, SRAM_CE_N, SRAM_OE_N
    );

endinterface

// File: rtl/sram_responder_byte_array.sv
// Word array with a synchronous byte-lane-masked write port and an
// asynchronous read port. Contents are deliberately not reset.
module sram_byte_array #(
    parameter int ADDR_W = 16
) (
    input  logic              i_clk,
    input  logic              i_we_lo,
    input  logic              i_we_hi,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [15:0]       i_wdata,
    output logic [15:0]       o_rdata
);

    logic [15:0] r_mem [0:(1<<ADDR_W)-1];

    // Commit each enabled byte lane at the sampling edge.
    always_ff @(posedge i_clk) begin
        if (i_we_lo) r_mem[i_addr][7:0]  <= i_wdata[7:0];
        if (i_we_hi) r_mem[i_addr][15:8] <= i_wdata[15:8];
    end

    assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/sram_responder.sv
// Behavioural stand-in for the external 16-bit SRAM: decodes the controller
// strobes, services lane-masked reads/writes and returns read data on DQ
// after READ_LAT stable read samples, from registered data and enables only.
module sram_responder
    import sram_pkg::*;
#(
    parameter int DEPTH_W  = 16,
    parameter int READ_LAT = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    sram_responder_if.slave        bus,
    inout  wire  [SRAM_DATA_W-1:0] SRAM_DQ,
    output logic                   conflict,
    output logic [15:0]            rd_count,
    output logic [15:0]            wr_count
);

    localparam logic [2:0] LP_LAT = 3'(READ_LAT);

    sram_rsp_state_t        r_state, w_nxt_state;
    sram_req_t              w_req;
    logic [2:0]             r_lat_cnt, w_nxt_lat, w_lat_inc;
    logic [SRAM_ADDR_W-1:0] r_addr, w_nxt_addr;
    logic [15:0]            r_data_q, w_rdata;
    logic                   r_oe_lo, r_oe_hi;
    logic                   w_same_addr, w_enter_drive, w_enter_write;
    logic                   w_we_lo, w_we_hi;

    assign w_req       = decode_req(bus.SRAM_CE_N, bus.SRAM_WE_N, bus.SRAM_OE_N);
    assign w_same_addr = (bus.SRAM_ADDR == r_addr);
    assign w_lat_inc   = r_lat_cnt + 3'd1;
    assign w_we_lo     = (w_req == WR) && !bus.SRAM_LB_N;
    assign w_we_hi     = (w_req == WR) && !bus.SRAM_UB_N;

    sram_byte_array #(.ADDR_W(DEPTH_W)) u_array (
        .i_clk   (clk),
        .i_we_lo (w_we_lo),
        .i_we_hi (w_we_hi),
        .i_addr  (bus.SRAM_ADDR[DEPTH_W-1:0]),
        .i_wdata (SRAM_DQ),
        .o_rdata (w_rdata)
    );

    // Next-state, latency count and latched read address from the decoded request.
    always_comb begin
        w_nxt_state = r_state;
        w_nxt_lat   = r_lat_cnt;
        w_nxt_addr  = r_addr;
        case (w_req)
            WR: begin
                w_nxt_state = WRITE;
                w_nxt_lat   = '0;
            end
            RD: begin
                if (r_state == READ_WAIT && w_same_addr) begin
                    w_nxt_lat = w_lat_inc;
                    if (w_lat_inc == LP_LAT) w_nxt_state = READ_DRIVE;
                end else if (!(r_state == READ_DRIVE && w_same_addr)) begin
                    // Any new read (from idle, write or an address change)
                    // restarts the stability count on the new address.
                    w_nxt_lat   = 3'd1;
                    w_nxt_addr  = bus.SRAM_ADDR;
                    w_nxt_state = (LP_LAT == 3'd1) ? READ_DRIVE : READ_WAIT;
                end
            end
            default: begin
                w_nxt_state = IDLE;
                w_nxt_lat   = '0;
            end
        endcase
    end

    assign w_enter_drive = (w_nxt_state == READ_DRIVE) &&
                           (r_state != READ_DRIVE || !w_same_addr);
    assign w_enter_write = (w_req == WR) && (r_state != WRITE);

    // FSM state, read data register and registered per-lane output enables.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= IDLE;
            r_lat_cnt <= '0;
            r_addr    <= '0;
            r_data_q  <= '0;
            r_oe_lo   <= 1'b0;
            r_oe_hi   <= 1'b0;
        end else begin
            r_state   <= w_nxt_state;
            r_lat_cnt <= w_nxt_lat;
            r_addr    <= w_nxt_addr;
            if (w_nxt_state == READ_DRIVE) r_data_q <= w_rdata;
            r_oe_lo   <= (w_nxt_state == READ_DRIVE) && !bus.SRAM_LB_N;
            r_oe_hi   <= (w_nxt_state == READ_DRIVE) && !bus.SRAM_UB_N;
        end
    end

    // Sticky conflict flag and wrapping transaction counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            conflict <= 1'b0;
            rd_count <= '0;
            wr_count <= '0;
        end else begin
            if (w_req == WR && !bus.SRAM_OE_N) conflict <= 1'b1;
            if (w_enter_drive) rd_count <= rd_count + 16'd1;
            if (w_enter_write) wr_count <= wr_count + 16'd1;
        end
    end

    assign SRAM_DQ[7:0]  = r_oe_lo ? r_data_q[7:0]  : 'z;
    assign SRAM_DQ[15:8] = r_oe_hi ? r_data_q[15:8] : 'z;

endmodule

// File: tb/tb_sram_responder.sv
// Directed plus randomized bench for sram_responder. A behavioural model
// tracks memory contents, read stability run length and counters; a weak
// pull-up makes any released DQ lane read back as 8'hFF.
module tb_sram_responder;

    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    wire  [15:0] dq;
    logic [15:0] tb_dq = '0;
    logic        tb_dq_en = 1'b0;
    logic        conflict;
    logic [15:0] rd_count, wr_count;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    sram_responder_if bus ();

    sram_responder #(.DEPTH_W(16), .READ_LAT(LAT)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .SRAM_DQ  (dq),
        .conflict (conflict),
        .rd_count (rd_count),
        .wr_count (wr_count)
    );

    assign dq = tb_dq_en ? tb_dq : 'z;
    pullup pu_dq (dq);

    always #5 clk = ~clk;

    // ---------------- behavioural reference model ----------------
    logic [15:0] m_mem [0:65535];
    int unsigned m_run;
    logic        m_prev_wr, m_prev_rd;
    logic [17:0] m_prev_addr;
    logic [15:0] m_rd_cnt, m_wr_cnt, m_rdata;
    logic        m_conflict, m_drv_lo, m_drv_hi;

    task automatic model_reset();
        m_run = 0; m_prev_wr = 1'b0; m_prev_rd = 1'b0; m_prev_addr = '0;
        m_rd_cnt = '0; m_wr_cnt = '0; m_conflict = 1'b0;
        m_drv_lo = 1'b0; m_drv_hi = 1'b0; m_rdata = '0;
    endtask

    task automatic model_step();
        logic        is_wr, is_rd;
        logic [15:0] idx;
        is_wr = !bus.SRAM_CE_N && !bus.SRAM_WE_N;
        is_rd = !bus.SRAM_CE_N && bus.SRAM_WE_N && !bus.SRAM_OE_N;
        idx   = bus.SRAM_ADDR[15:0];
        if (is_wr) begin
            if (!bus.SRAM_OE_N) m_conflict = 1'b1;
            if (!m_prev_wr) m_wr_cnt = m_wr_cnt + 16'd1;
            if (!bus.SRAM_LB_N) m_mem[idx][7:0]  = tb_dq[7:0];
            if (!bus.SRAM_UB_N) m_mem[idx][15:8] = tb_dq[15:8];
        end
        if (is_rd) begin
            m_run = (m_prev_rd && bus.SRAM_ADDR == m_prev_addr) ? m_run + 1 : 1;
            if (m_run == LAT) m_rd_cnt = m_rd_cnt + 16'd1;
        end else begin
            m_run = 0;
        end
        m_drv_lo = is_rd && (m_run >= LAT) && !bus.SRAM_LB_N;
        m_drv_hi = is_rd && (m_run >= LAT) && !bus.SRAM_UB_N;
        if (is_rd && m_run >= LAT) m_rdata = m_mem[idx];
        m_prev_rd = is_rd; m_prev_wr = is_wr; m_prev_addr = bus.SRAM_ADDR;
    endtask

    function automatic logic [15:0] exp_dq();
        if (tb_dq_en) return tb_dq;
        return {m_drv_hi ? m_rdata[15:8] : 8'hFF, m_drv_lo ? m_rdata[7:0] : 8'hFF};
    endfunction

    // ---------------- checking ----------------
    task automatic cmp(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        cmp("dq", dq, exp_dq());
        cmp("rd_count", rd_count, m_rd_cnt);
        cmp("wr_count", wr_count, m_wr_cnt);
        cmp("conflict", {15'b0, conflict}, {15'b0, m_conflict});
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic drive(input logic ce_n, input logic we_n, input logic oe_n,
                         input logic ub_n, input logic lb_n,
                         input logic [17:0] addr, input logic [15:0] data);
        bus.SRAM_CE_N = ce_n; bus.SRAM_WE_N = we_n; bus.SRAM_OE_N = oe_n;
        bus.SRAM_UB_N = ub_n; bus.SRAM_LB_N = lb_n; bus.SRAM_ADDR = addr;
        tb_dq    = data;
        tb_dq_en = !ce_n && !we_n;
    endtask

    task automatic cycle();
        @(posedge clk);
        if (!rst) model_reset();
        else      model_step();
        #1;
        check_all();
    endtask

    task automatic wr(input logic [17:0] a, input logic [15:0] d,
                      input logic ub_n, input logic lb_n);
        drive(1'b0, 1'b1 ^ 1'b1, 1'b1, ub_n, lb_n, a, d);
        cycle();
    endtask

    task automatic rd(input logic [17:0] a, input logic ub_n, input logic lb_n);
        drive(1'b0, 1'b1, 1'b0, ub_n, lb_n, a, '0);
        cycle();
    endtask

    task automatic idle();
        drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, '0, '0);
        cycle();
    endtask

    function automatic logic [17:0] pick_addr();
        logic [17:0] a;
        a = 18'h00040 + 18'($urandom_range(0, 7));
        a[17:16] = 2'($urandom_range(0, 3));
        return a;
    endfunction

    // ---------------- directed and random sequence ----------------
    initial begin
        int unsigned kind, n, sw;
        logic [17:0] a;

        model_reset();
        drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, '0, '0);
        cycle();
        cmp("reset_dq", dq, 16'hFFFF);
        cmp("reset_rd", rd_count, 16'd0);
        cmp("reset_wr", wr_count, 16'd0);
        cmp("reset_conflict", {15'b0, conflict}, 16'd0);
        cycle();
        @(negedge clk) rst = 1'b1;
        idle();

        // Write then read back with both lanes.
        wr(18'h00010, 16'hBEEF, 1'b0, 1'b0);
        rd(18'h00010, 1'b0, 1'b0);
        cmp("beef_wait_dq", dq, 16'hFFFF);
        rd(18'h00010, 1'b0, 1'b0);
        cmp("beef_dq", dq, 16'hBEEF);
        cmp("beef_wr", wr_count, 16'd1);
        cmp("beef_rd", rd_count, 16'd1);
        idle();

        // Byte-lane masking on write and on read.
        wr(18'h00020, 16'h1234, 1'b0, 1'b0);
        idle();
        wr(18'h00020, 16'hAB00, 1'b0, 1'b1);
        idle();
        rd(18'h00020, 1'b1, 1'b0);
        rd(18'h00020, 1'b1, 1'b0);
        cmp("lane_lo_only", dq, 16'hFF34);
        idle();
        rd(18'h00020, 1'b0, 1'b0);
        rd(18'h00020, 1'b0, 1'b0);
        cmp("lane_full", dq, 16'hAB34);
        idle();

        // Preload the addresses used below as one write burst.
        wr(18'h00030, 16'h3030, 1'b0, 1'b0);
        wr(18'h00031, 16'h3131, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) wr(18'h00040 + 18'(i), 16'($urandom), 1'b0, 1'b0);
        idle();

        // Address change one cycle before data would be valid.
        rd(18'h00030, 1'b0, 1'b0);
        rd(18'h00031, 1'b0, 1'b0);
        cmp("addr_change_dq", dq, 16'hFFFF);
        rd(18'h00031, 1'b0, 1'b0);
        cmp("addr_change_data", dq, 16'h3131);
        cmp("addr_change_rd", rd_count, 16'd4);
        idle();

        // Write with OE_N low: flag is sticky and the write still lands.
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 18'h00005, 16'h5555);
        cycle();
        cmp("conflict_set", {15'b0, conflict}, 16'd1);
        idle();
        cmp("conflict_sticky", {15'b0, conflict}, 16'd1);
        rd(18'h00005, 1'b0, 1'b0);
        rd(18'h00005, 1'b0, 1'b0);
        cmp("conflict_data", dq, 16'h5555);
        idle();

        // Upper address bits alias onto the implemented range.
        wr(18'h10007, 16'hC0DE, 1'b0, 1'b0);
        idle();
        rd(18'h00007, 1'b0, 1'b0);
        rd(18'h00007, 1'b0, 1'b0);
        cmp("alias_data", dq, 16'hC0DE);
        idle();

        // Randomized traffic over a small aliased address pool.
        for (int t = 0; t < 120; t++) begin
            kind = $urandom_range(0, 9);
            a    = pick_addr();
            if (kind < 4) begin
                n = $urandom_range(1, 3);
                for (int i = 0; i < int'(n); i++)
                    wr(pick_addr(), 16'($urandom), 1'($urandom_range(0, 1)),
                       1'($urandom_range(0, 1)));
            end else if (kind < 8) begin
                n  = $urandom_range(1, 5);
                sw = $urandom_range(0, 6);
                for (int i = 0; i < int'(n); i++) begin
                    if (i == int'(sw)) a = pick_addr();
                    rd(a, 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) == 0));
                end
            end else if (kind == 8) begin
                idle();
            end else begin
                drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, a, '0);
                cycle();
            end
        end
        idle();

        // Asynchronous reset while driving read data.
        rd(18'h00030, 1'b0, 1'b0);
        rd(18'h00030, 1'b0, 1'b0);
        cmp("pre_reset_dq", dq, 16'h3030);
        #3 rst = 1'b0;
        #1;
        model_reset();
        cmp("async_rst_dq", dq, 16'hFFFF);
        cmp("async_rst_rd", rd_count, 16'd0);
        cmp("async_rst_wr", wr_count, 16'd0);
        cmp("async_rst_conflict", {15'b0, conflict}, 16'd0);
        idle();
        @(negedge clk) rst = 1'b1;
        idle();
        cmp("post_rst_rd", rd_count, 16'd0);
        rd(18'h00031, 1'b0, 1'b0);
        cmp("post_rst_wait_dq", dq, 16'hFFFF);
        rd(18'h00031, 1'b0, 1'b0);
        cmp("post_rst_data", dq, 16'h3131);
        cmp("post_rst_rd_one", rd_count, 16'd1);
        idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
